// File: rtl/dmem_store_buffer_if.sv
// Store-buffer bus: control-unit store requests, memory write port,
// load-forwarding lookup and buffer status.
interface dmem_store_buffer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              run;
    logic              c_store;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic              mem_busy;
    logic [ADDR_W-1:0] ld_addr;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              full;
    logic              empty;
    logic              stall;

    // Control unit / memory side
    modport master (
        output run, c_store, store_addr, store_data, mem_busy, ld_addr,
        input  dmem_we, dmem_waddr, dmem_wdata, fwd_hit, fwd_data, full, empty, stall
    );

    // Store buffer side
    modport slave (
        input  run, c_store, store_addr, store_data, mem_busy, ld_addr,
        output dmem_we, dmem_waddr, dmem_wdata, fwd_hit, fwd_data, full, empty, stall
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer for the i281 data memory: FIFO of pending stores, drained one
// per cycle when the memory is not reading, with load forwarding from the
// youngest matching pending store.

// Per-entry address comparator for the forwarding lookup.
module dmem_sb_match #(
    parameter int ADDR_W = 4
) (
    input  logic              valid,
    input  logic [ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit
);
    assign hit = valid && (entry_addr == ld_addr);
endmodule

module dmem_store_buffer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic               clock,
    input  logic               reset,
    dmem_store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointers wrap by natural overflow, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_store_buffer: DEPTH must be a power of two >= 2");
    end

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [CNT_W-1:0]             count;
    logic                         is_full;
    logic                         is_empty;
    logic                         enq;
    logic                         drain;
    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0]             ent_hit;
    logic                         hit_c;
    logic [DATA_W-1:0]            hit_data_c;
    logic [PTR_W-1:0]             scan_idx;

    assign is_full  = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);

    // A full buffer refuses even when a drain frees a slot this same cycle;
    // this keeps stall independent of mem_busy.
    assign enq   = bus.c_store && bus.run && !is_full;
    assign drain = !is_empty && !bus.mem_busy && bus.run;

    assign bus.stall      = bus.c_store && bus.run && is_full;
    assign bus.dmem_we    = drain;
    assign bus.dmem_waddr = is_empty ? '0 : ent_addr[head];
    assign bus.dmem_wdata = is_empty ? '0 : ent_data[head];
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.fwd_hit    = hit_c;
    assign bus.fwd_data   = hit_data_c;

    // Pointer and occupancy bookkeeping; simultaneous enq+drain leaves count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            case ({enq, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: the accepted store lands at the tail slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_addr <= '0;
            ent_data <= '0;
        end else if (enq) begin
            ent_addr[tail] <= bus.store_addr;
            ent_data[tail] <= bus.store_data;
        end
    end

    // An entry is live when its distance from head is below count; the head
    // being drained this cycle still counts, so a load sees it until it is written.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] age;
        assign age        = PTR_W'(i) - head;
        assign ent_vld[i] = ({1'b0, age} < count);

        dmem_sb_match #(.ADDR_W(ADDR_W)) u_match (
            .valid      (ent_vld[i]),
            .entry_addr (ent_addr[i]),
            .ld_addr    (bus.ld_addr),
            .hit        (ent_hit[i])
        );
    end

    // Scan from oldest to youngest so the last hit seen (closest to tail) wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        scan_idx   = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if (ent_hit[scan_idx]) begin
                hit_c      = 1'b1;
                hit_data_c = ent_data[scan_idx];
            end
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic with occasional asynchronous resets.
module tb_dmem_store_buffer;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];

    dmem_store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dmem_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending stores as a plain queue, oldest at index 0.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            automatic bit do_enq = bus.c_store && bus.run && (mq.size() < DEPTH);
            automatic bit do_drn = (mq.size() > 0) && !bus.mem_busy && bus.run;
            if (do_drn) void'(mq.pop_front());
            if (do_enq) mq.push_back('{a: bus.store_addr, d: bus.store_data});
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    always @(negedge clock) begin
        if (!reset) begin
            automatic bit             e_hit = 1'b0;
            automatic logic [DATA_W-1:0] e_fd = '0;
            automatic bit             e_full = (mq.size() == DEPTH);
            automatic bit             e_empty = (mq.size() == 0);
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!e_hit && mq[i].a == bus.ld_addr) begin
                    e_hit = 1'b1;
                    e_fd  = mq[i].d;
                end
            end
            chk("m_empty", bus.empty, e_empty);
            chk("m_full", bus.full, e_full);
            chk("m_stall", bus.stall, bus.c_store && bus.run && e_full);
            chk("m_we", bus.dmem_we, !e_empty && !bus.mem_busy && bus.run);
            chk("m_waddr", bus.dmem_waddr, e_empty ? '0 : mq[0].a);
            chk("m_wdata", bus.dmem_wdata, e_empty ? '0 : mq[0].d);
            chk("m_fwd_hit", bus.fwd_hit, e_hit);
            chk("m_fwd_data", bus.fwd_data, e_fd);
        end
    end

    // Apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic cs, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic mb, input logic [ADDR_W-1:0] la, input logic rn);
        @(posedge clock);
        #1;
        bus.c_store    = cs;
        bus.store_addr = a;
        bus.store_data = d;
        bus.mem_busy   = mb;
        bus.ld_addr    = la;
        bus.run        = rn;
    endtask

    initial begin
        bus.c_store = 0; bus.store_addr = '0; bus.store_data = '0;
        bus.mem_busy = 0; bus.ld_addr = '0; bus.run = 1;
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_fwd_hit", bus.fwd_hit, 0);
        chk("rst_waddr", bus.dmem_waddr, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_fwd_data", bus.fwd_data, 0);
        @(posedge clock); #1 reset = 0;

        // Single store: written on the following cycle, head visible to a load.
        drive(1, 4'd3, 8'hA5, 0, 4'd3, 1); #2;
        chk("t1_we0", bus.dmem_we, 0);
        chk("t1_same_cycle_fwd", bus.fwd_hit, 0);
        drive(0, 4'd0, 8'h00, 0, 4'd3, 1); #2;
        chk("t1_we", bus.dmem_we, 1);
        chk("t1_waddr", bus.dmem_waddr, 3);
        chk("t1_wdata", bus.dmem_wdata, 8'hA5);
        chk("t1_fwd_head", bus.fwd_data, 8'hA5);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t1_empty", bus.empty, 1);
        chk("t1_we_off", bus.dmem_we, 0);

        // Fill while memory busy, fifth store refused, then ordered drain.
        for (int i = 1; i <= 4; i++) drive(1, ADDR_W'(i), DATA_W'(i * 8'h11), 1, 4'd0, 1);
        drive(1, 4'd5, 8'h55, 1, 4'd0, 1); #2;
        chk("t2_full", bus.full, 1);
        chk("t2_stall", bus.stall, 1);
        drive(0, 4'd0, 8'h00, 1, 4'd0, 1); #2;
        chk("t2_still_full", bus.full, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
            chk("t2_drain_we", bus.dmem_we, 1);
            chk("t2_drain_addr", bus.dmem_waddr, i);
            chk("t2_drain_data", bus.dmem_wdata, i * 8'h11);
        end
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t2_empty", bus.empty, 1);

        // Forwarding picks the youngest duplicate; current enqueue not visible.
        drive(1, 4'd5, 8'h10, 1, 4'd0, 1);
        drive(1, 4'd5, 8'h20, 1, 4'd0, 1);
        drive(1, 4'd7, 8'h77, 1, 4'd5, 1); #2;
        chk("t3_hit5", bus.fwd_hit, 1);
        chk("t3_data5", bus.fwd_data, 8'h20);
        drive(0, 4'd0, 8'h00, 1, 4'd6, 1); #2;
        chk("t3_miss6", bus.fwd_hit, 0);
        chk("t3_miss6_data", bus.fwd_data, 0);
        drive(0, 4'd0, 8'h00, 1, 4'd7, 1); #2;
        chk("t3_hit7", bus.fwd_hit, 1);
        chk("t3_data7", bus.fwd_data, 8'h77);
        for (int i = 0; i < 4; i++) drive(0, 4'd0, 8'h00, 0, 4'd0, 1);

        // Steady state at count 2 with simultaneous enqueue and drain, wrapping pointers.
        drive(1, 4'd8, 8'h81, 1, 4'd0, 1);
        drive(1, 4'd9, 8'h91, 1, 4'd0, 1);
        for (int i = 0; i < 12; i++) begin
            drive(1, ADDR_W'(i), DATA_W'(8'hC0 + i), 0, 4'd0, 1); #2;
            chk("t4_we", bus.dmem_we, 1);
            chk("t4_not_full", bus.full, 0);
            chk("t4_not_empty", bus.empty, 0);
            if (i == 0) chk("t4_first_addr", bus.dmem_waddr, 8);
            if (i == 1) chk("t4_second_addr", bus.dmem_waddr, 9);
            if (i >= 2) chk("t4_wrap_data", bus.dmem_wdata, 8'hC0 + i - 2);
        end
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t4_empty", bus.empty, 1);

        // run=0 freezes everything except forwarding.
        drive(1, 4'hA, 8'hAA, 1, 4'd0, 1);
        drive(1, 4'hB, 8'hBB, 1, 4'd0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 4'hC, 8'hCC, 0, 4'hA, 0); #2;
            chk("t5_we_off", bus.dmem_we, 0);
            chk("t5_stall_off", bus.stall, 0);
            chk("t5_fwd", bus.fwd_data, 8'hAA);
            chk("t5_head", bus.dmem_waddr, 4'hA);
        end
        drive(1, 4'hC, 8'hCC, 0, 4'hB, 1); #2;
        chk("t5_resume_we", bus.dmem_we, 1);
        chk("t5_resume_addr", bus.dmem_waddr, 4'hA);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t5_next_addr", bus.dmem_waddr, 4'hB);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t5_enq_addr", bus.dmem_waddr, 4'hC);
        chk("t5_enq_data", bus.dmem_wdata, 8'hCC);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t5_empty", bus.empty, 1);

        // Asynchronous reset mid-cycle discards pending stores.
        drive(1, 4'd1, 8'h01, 1, 4'd0, 1);
        drive(1, 4'd2, 8'h02, 1, 4'd0, 1);
        drive(1, 4'd3, 8'h03, 1, 4'd0, 1);
        drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
        chk("t6_pre_we", bus.dmem_we, 1);
        #1 reset = 1;
        #1;
        chk("t6_async_empty", bus.empty, 1);
        chk("t6_async_we", bus.dmem_we, 0);
        chk("t6_async_waddr", bus.dmem_waddr, 0);
        @(posedge clock); #1 reset = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 8'h00, 0, 4'd0, 1); #2;
            chk("t6_no_write", bus.dmem_we, 0);
        end

        // Random traffic; model comparison runs every cycle.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clock);
            #1;
            reset          = 0;
            bus.c_store    = ($urandom_range(0, 99) < 55);
            bus.store_addr = ADDR_W'($urandom_range(0, 7));
            bus.store_data = DATA_W'($urandom);
            bus.mem_busy   = ($urandom_range(0, 99) < 40);
            bus.ld_addr    = ADDR_W'($urandom_range(0, 7));
            bus.run        = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1;
            end
        end
        @(posedge clock); #1 reset = 0;
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
